// File: rtl/row_line_buffer_pkg.sv
// Shared defaults and FSM encoding for the row line buffer.
package row_line_buffer_pkg;
  localparam int BIT_DEPTH_DEF  = 8;
  localparam int IMG_WIDTH_DEF  = 28;
  localparam int IMG_HEIGHT_DEF = 28;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;
endpackage

// File: rtl/row_line_buffer_line_ram.sv
// Single-port line RAM: synchronous write, combinational read.
// A write and a read at the same address in one cycle return the old word.
module line_ram #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/row_line_buffer.sv
// Raster-stream line buffer: emits three vertically aligned pixels per
// accepted pixel once two full rows of the frame have been stored.
module row_line_buffer
  import row_line_buffer_pkg::*;
#(
  parameter int BIT_DEPTH  = BIT_DEPTH_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  input  logic [BIT_DEPTH-1:0]          pix_in,
  output logic                          out_valid,
  output logic [BIT_DEPTH-1:0]          row1,
  output logic [BIT_DEPTH-1:0]          row2,
  output logic [BIT_DEPTH-1:0]          row3,
  output logic                          win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_idx,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_idx,
  output logic                          frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]        c;
  logic [RW-1:0]        r;
  state_t               state;
  logic [BIT_DEPTH-1:0] old_q;
  logic [BIT_DEPTH-1:0] new_q;
  logic                 last_col;
  logic                 last_row;

  assign last_col = (c == CW'(IMG_WIDTH - 1));
  assign last_row = (r == RW'(IMG_HEIGHT - 1));

  // The newer row shifts into the older RAM as the incoming pixel replaces it.
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(BIT_DEPTH)) u_lb_old (
    .clk   (clk),
    .we    (pix_valid),
    .addr  (c),
    .wdata (new_q),
    .rdata (old_q)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(BIT_DEPTH)) u_lb_new (
    .clk   (clk),
    .we    (pix_valid),
    .addr  (c),
    .wdata (pix_in),
    .rdata (new_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c          <= '0;
      r          <= '0;
      state      <= FILL;
      out_valid  <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      row1       <= '0;
      row2       <= '0;
      row3       <= '0;
      col_idx    <= '0;
      row_idx    <= '0;
    end else begin
      out_valid  <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        row1       <= old_q;
        row2       <= new_q;
        row3       <= pix_in;
        col_idx    <= c;
        row_idx    <= r;
        out_valid  <= (state == STREAM);
        win_valid  <= (state == STREAM) && (c >= CW'(2));
        frame_done <= last_col && last_row;

        if (last_col) begin
          c <= '0;
          r <= last_row ? '0 : r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end

        case (state)
          FILL:    if (last_col && r == RW'(1)) state <= STREAM;
          STREAM:  if (last_col && last_row)    state <= FILL;
          default: state <= FILL;
        endcase
      end
    end
  end
endmodule
